// File: rtl/ascon_pack.sv
// Shared ASCON types and constants for the permutation datapath and its sequencer.
package ascon_pack;

  // x0..x4 as five 64-bit words; index 0 is x0
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    ROUNDS_12 = 2'b00,
    ROUNDS_8  = 2'b01,
    ROUNDS_6  = 2'b10
  } type_rounds;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } type_seq_fsm;

  localparam logic [3:0] FIRST_ROUND_12 = 4'd0;
  localparam logic [3:0] FIRST_ROUND_8  = 4'd4;
  localparam logic [3:0] FIRST_ROUND_6  = 4'd6;

endpackage

// File: rtl/permutation_elementaire.sv
// One ASCON round: constant addition, bitsliced 5-bit S-box layer, linear diffusion.
module permutation_elementaire
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  function automatic logic [63:0] rotr(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;
  logic [63:0] d0, d1, d2, d3, d4;

  // Round constant is ((15 - r) << 4) | r, i.e. {~r, r}
  assign a0 = state_i[0];
  assign a1 = state_i[1];
  assign a2 = state_i[2] ^ {56'd0, ~round_i, round_i};
  assign a3 = state_i[3];
  assign a4 = state_i[4];

  assign b0 = a0 ^ a4;
  assign b1 = a1;
  assign b2 = a2 ^ a1;
  assign b3 = a3;
  assign b4 = a4 ^ a3;

  assign c0 = b0 ^ (~b1 & b2);
  assign c1 = b1 ^ (~b2 & b3);
  assign c2 = b2 ^ (~b3 & b4);
  assign c3 = b3 ^ (~b4 & b0);
  assign c4 = b4 ^ (~b0 & b1);

  assign d0 = c0 ^ c4;
  assign d1 = c1 ^ c0;
  assign d2 = ~c2;
  assign d3 = c3 ^ c2;
  assign d4 = c4;

  assign state_o[0] = d0 ^ rotr(d0, 19) ^ rotr(d0, 28);
  assign state_o[1] = d1 ^ rotr(d1, 61) ^ rotr(d1, 39);
  assign state_o[2] = d2 ^ rotr(d2, 1)  ^ rotr(d2, 6);
  assign state_o[3] = d3 ^ rotr(d3, 10) ^ rotr(d3, 17);
  assign state_o[4] = d4 ^ rotr(d4, 7)  ^ rotr(d4, 41);

endmodule

// File: rtl/ascon_perm_sequencer.sv
// Iterates one ASCON round per clock to build p^12 / p^8 / p^6 with a start/done handshake.
module ascon_perm_sequencer
  import ascon_pack::*;
#(
  parameter logic [3:0] ROUND_LAST = 4'd11
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] rounds_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] round_o
);

  type_seq_fsm fsm_q;
  type_state   state_q;
  type_state   state_nxt;
  logic [3:0]  cnt_q;
  logic [3:0]  first_round;

  permutation_elementaire p_round (
    .state_i (state_q),
    .round_i (cnt_q),
    .state_o (state_nxt)
  );

  // Shorter permutations run the tail of the 12-round schedule; 2'b11 falls back to 12
  always_comb begin
    first_round = FIRST_ROUND_12;
    case (rounds_i)
      ROUNDS_8: first_round = FIRST_ROUND_8;
      ROUNDS_6: first_round = FIRST_ROUND_6;
      default:  first_round = FIRST_ROUND_12;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state_q <= state_i;
            cnt_q   <= first_round;
            busy_o  <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= state_nxt;
          if (cnt_q == ROUND_LAST) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            fsm_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          fsm_q  <= IDLE;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign round_o = cnt_q;

endmodule
